// File: rtl/lfsr_pkg.sv
// Shared types and the LFSR next-state function used by lfsr_gen.
// The step function works on a fixed-size word; callers pass their real width.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  localparam int unsigned LFSR_MAX_WIDTH = 32;

  typedef logic [LFSR_MAX_WIDTH-1:0] lfsr_word_t;

  // Bits at and above `width` are ignored on input and cleared on output.
  function automatic lfsr_word_t lfsr_next(
    input lfsr_word_t  state,
    input lfsr_word_t  taps,
    input lfsr_mode_e  mode,
    input int unsigned width
  );
    lfsr_word_t mask;
    lfsr_word_t s;
    logic       fb;
    mask = {LFSR_MAX_WIDTH{1'b1}} >> (LFSR_MAX_WIDTH - width);
    s    = state & mask;
    fb   = ^(s & taps & mask);
    if (mode == LFSR_FIB) begin
      lfsr_next = ((s << 1) | lfsr_word_t'(fb)) & mask;
    end else begin
      lfsr_next = (s >> 1) ^ (s[0] ? (taps & mask) : '0);
    end
  endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// On-line period monitor: remembers the reference state and counts steps
// until the sequence returns to it.
module lfsr_period_mon
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             load_i,
  input  logic             resync_i,
  input  logic [WIDTH-1:0] state_d_i,
  output logic             period_hit,
  output logic [WIDTH-1:0] period_len
);

  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             hit_q, hit_d;
  logic [WIDTH-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ref_d = ref_q;
    cnt_d = cnt_q;
    len_d = len_q;
    hit_d = 1'b0;
    if (load_i) begin
      ref_d = state_d_i;
      cnt_d = '0;
    end else if (step_i) begin
      if (resync_i) begin
        // A mode change starts a fresh period from the state just reached.
        ref_d = state_d_i;
        cnt_d = '0;
      end else if (state_d_i == ref_q) begin
        hit_d = 1'b1;
        len_d = cnt_inc;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q <= DEFAULT_SEED;
      cnt_q <= '0;
      len_q <= '0;
      hit_q <= 1'b0;
    end else begin
      ref_q <= ref_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      hit_q <= hit_d;
    end
  end

  assign period_hit = hit_q;
  assign period_len = len_q;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, zero-seed recovery
// and an on-line period monitor.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mode,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             bit_out,
  output logic             period_hit,
  output logic [WIDTH-1:0] period_len,
  output logic             lockup
);

  logic [WIDTH-1:0] state_q, state_d;
  lfsr_mode_e       mode_q, mode_d;
  logic             lockup_q, lockup_d;

  lfsr_mode_e       mode_cur;
  logic             step;
  logic             mode_change;
  logic             load_zero;
  logic [WIDTH-1:0] load_state;
  logic [WIDTH-1:0] step_state;

  assign mode_cur    = lfsr_mode_e'(mode);
  assign step        = enable & ~load;
  assign mode_change = step & (mode_cur != mode_q);
  assign load_zero   = (data_in == '0);
  assign load_state  = load_zero ? DEFAULT_SEED : data_in;
  assign step_state  = WIDTH'(lfsr_next(lfsr_word_t'(state_q), lfsr_word_t'(TAPS),
                                        mode_cur, WIDTH));

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    lockup_d = 1'b0;
    if (load) begin
      state_d  = load_state;
      lockup_d = load_zero;
    end else if (enable) begin
      state_d = step_state;
      mode_d  = mode_cur;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DEFAULT_SEED;
      mode_q   <= LFSR_FIB;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      lockup_q <= lockup_d;
    end
  end

  lfsr_period_mon #(
    .WIDTH        (WIDTH),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_period_mon (
    .clk        (clk),
    .rst        (rst),
    .step_i     (step),
    .load_i     (load),
    .resync_i   (mode_change),
    .state_d_i  (state_d),
    .period_hit (period_hit),
    .period_len (period_len)
  );

  assign lfsr_out = state_q;
  assign bit_out  = (mode_cur == LFSR_FIB) ? state_q[WIDTH-1] : state_q[0];
  assign lockup   = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen (WIDTH=8, TAPS=0xB8, DEFAULT_SEED=0x01).
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       mode = 1'b0;
  logic [7:0] lfsr_out;
  logic       bit_out;
  logic       period_hit;
  logic [7:0] period_len;
  logic       lockup;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_gen #(
    .WIDTH        (8),
    .TAPS         (8'hB8),
    .DEFAULT_SEED (8'h01)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .data_in    (data_in),
    .mode       (mode),
    .lfsr_out   (lfsr_out),
    .bit_out    (bit_out),
    .period_hit (period_hit),
    .period_len (period_len),
    .lockup     (lockup)
  );

  task automatic do_step(input logic m);
    @(negedge clk);
    mode   = m;
    enable = 1'b1;
    load   = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v, input logic m, input logic en);
    @(negedge clk);
    data_in = v;
    mode    = m;
    load    = 1'b1;
    enable  = en;
    @(posedge clk);
    #1;
    load   = 1'b0;
    enable = 1'b0;
  endtask

  task automatic do_idle(input int n, input logic [7:0] held);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      enable = 1'b0;
      load   = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (lfsr_out !== held || period_hit !== 1'b0 || lockup !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: got out=%h hit=%b lock=%b expected out=%h hit=0 lock=0",
                 lfsr_out, period_hit, lockup, held);
      end
    end
  endtask

  // Runs n steps from the current state; a hit is expected only on step n.
  task automatic run_period(input string name, input logic m, input int n,
                            input int gap_at);
    logic exp_hit;
    for (int i = 1; i <= n; i++) begin
      do_step(m);
      exp_hit = (i == n);
      checks++;
      if (period_hit !== exp_hit) begin
        errors++;
        $display("FAIL %s_hit step %0d: got %b expected %b", name, i, period_hit, exp_hit);
      end
      if (i == gap_at) do_idle(3, lfsr_out);
    end
    checks++;
    if (period_len !== 8'd255 || lfsr_out !== 8'h01) begin
      errors++;
      $display("FAIL %s_len: got len=%0d out=%h expected len=255 out=01",
               name, period_len, lfsr_out);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (lfsr_out !== 8'h01 || period_hit !== 1'b0 || lockup !== 1'b0 ||
        period_len !== 8'h00 || bit_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: got out=%h hit=%b lock=%b len=%h bit=%b expected 01 0 0 00 0",
               lfsr_out, period_hit, lockup, period_len, bit_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fibonacci;
    logic [7:0] exp_seq [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
    do_load(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_step(1'b0);
      checks++;
      if (lfsr_out !== exp_seq[i]) begin
        errors++;
        $display("FAIL fib_step %0d: got %h expected %h", i + 1, lfsr_out, exp_seq[i]);
      end
    end
    checks++;
    if (bit_out !== 1'b0) begin
      errors++;
      $display("FAIL fib_bit_out: got %b expected 0", bit_out);
    end
  endtask

  task automatic test_galois;
    logic [7:0] exp_seq [5] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    do_load(8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_step(1'b1);
      checks++;
      if (lfsr_out !== exp_seq[i]) begin
        errors++;
        $display("FAIL gal_step %0d: got %h expected %h", i + 1, lfsr_out, exp_seq[i]);
      end
    end
    checks++;
    if (bit_out !== 1'b1) begin
      errors++;
      $display("FAIL gal_bit_out: got %b expected 1", bit_out);
    end
  endtask

  task automatic test_period_fib;
    do_load(8'h01, 1'b0, 1'b0);
    run_period("period_fib", 1'b0, 255, 0);
  endtask

  task automatic test_period_gaps;
    do_load(8'h01, 1'b0, 1'b0);
    run_period("period_gaps", 1'b0, 255, 100);
  endtask

  task automatic test_period_gal;
    do_load(8'h01, 1'b1, 1'b0);
    run_period("period_gal", 1'b1, 255, 0);
    do_step(1'b1);
    checks++;
    if (period_len !== 8'd255 || period_hit !== 1'b0 || lfsr_out !== 8'hB8) begin
      errors++;
      $display("FAIL len_held: got len=%0d hit=%b out=%h expected 255 0 b8",
               period_len, period_hit, lfsr_out);
    end
  endtask

  task automatic test_zero_seed;
    do_load(8'h00, 1'b1, 1'b0);
    checks++;
    if (lfsr_out !== 8'h01 || lockup !== 1'b1) begin
      errors++;
      $display("FAIL zero_load: got out=%h lock=%b expected 01 1", lfsr_out, lockup);
    end
    do_idle(1, 8'h01);
    do_load(8'h5A, 1'b1, 1'b1);
    checks++;
    if (lfsr_out !== 8'h5A || lockup !== 1'b0 || period_hit !== 1'b0) begin
      errors++;
      $display("FAIL load_and_enable: got out=%h lock=%b hit=%b expected 5a 0 0",
               lfsr_out, lockup, period_hit);
    end
    do_load(8'h00, 1'b1, 1'b1);
    checks++;
    if (lfsr_out !== 8'h01 || lockup !== 1'b1) begin
      errors++;
      $display("FAIL zero_load_enable: got out=%h lock=%b expected 01 1", lfsr_out, lockup);
    end
  endtask

  task automatic test_mode_toggle;
    logic exp_hit;
    do_load(8'h01, 1'b0, 1'b0);
    for (int i = 1; i <= 355; i++) begin
      do_step(i >= 100);
      exp_hit = (i == 355);
      checks++;
      if (period_hit !== exp_hit) begin
        errors++;
        $display("FAIL toggle_hit step %0d: got %b expected %b", i, period_hit, exp_hit);
      end
    end
    checks++;
    if (period_len !== 8'd255) begin
      errors++;
      $display("FAIL toggle_len: got %0d expected 255", period_len);
    end
  endtask

  task automatic test_reset_midrun;
    do_load(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) do_step(1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (lfsr_out !== 8'h01 || period_hit !== 1'b0 || lockup !== 1'b0 ||
        period_len !== 8'h00) begin
      errors++;
      $display("FAIL reset_midrun: got out=%h hit=%b lock=%b len=%h expected 01 0 0 00",
               lfsr_out, period_hit, lockup, period_len);
    end
    @(negedge clk);
    rst = 1'b0;
    do_step(1'b0);
    checks++;
    if (lfsr_out !== 8'h02 || period_hit !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_step: got out=%h hit=%b expected 02 0", lfsr_out, period_hit);
    end
  endtask

  initial begin
    test_reset;
    test_fibonacci;
    test_period_fib;
    test_period_gaps;
    test_galois;
    test_period_gal;
    test_zero_seed;
    test_mode_toggle;
    test_reset_midrun;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
